// File: rtl/lab2_proc_mem_port_arbiter_pkg.sv
// lab2_proc_mem_arb_pkg: shared types, limits and tag helper for the memory port arbiter
package lab2_proc_mem_arb_pkg;
  localparam int ARB_MAX_REQS = 8;
  typedef logic [2:0] arb_id_t;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
  function automatic logic [7:0] arb_id_to_opaque(arb_id_t id);
    return {5'b0, id};
  endfunction
endpackage

// File: rtl/lab2_proc_rr_arbiter.sv
// lab2_proc_rr_arbiter: round-robin grant with hold while the granted request is stalled
module lab2_proc_rr_arbiter
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter int p_num_reqs = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] req_val,
  input  logic                  fire,
  input  logic                  hold,
  output logic [p_num_reqs-1:0] grant,
  output arb_id_t               grant_idx
);
  localparam int W = $clog2(p_num_reqs);
  logic [W-1:0] ptr, lock_id, idx, j;
  logic locked, found;
  // first valid requester at or after ptr, unless a stalled grant is being held
  always_comb begin
    idx = ptr;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < p_num_reqs; k++) begin
      j = W'((int'(ptr) + k) % p_num_reqs);
      if (!found && req_val[j]) begin
        found = 1'b1;
        idx = j;
      end
    end
    if (locked) begin
      idx = lock_id;
      found = 1'b1;
    end
    for (int i = 0; i < p_num_reqs; i++) grant[i] = found && (idx == W'(i));
    grant_idx = arb_id_t'(idx);
  end
  // rotate priority past the winner on fire; latch the grant while the port stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
      locked <= 1'b0;
      lock_id <= '0;
    end else if (fire) begin
      ptr <= (idx == W'(p_num_reqs - 1)) ? '0 : idx + 1'b1;
      locked <= 1'b0;
    end else if (hold) begin
      locked <= 1'b1;
      lock_id <= idx;
    end
  end
endmodule

// File: rtl/lab2_proc_mem_port_arbiter.sv
// lab2_proc_mem_port_arbiter: shares one memory port among requesters; LAB2_PROC_MEM_ARB_RESP_PIPE_EN adds a 2-entry response queue
module lab2_proc_mem_port_arbiter
  import lab2_proc_mem_arb_pkg::*;
#(
  parameter int p_num_reqs        = 2,
  parameter int p_max_outstanding = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  mem_req_4B_t           req_msg [p_num_reqs],
  input  logic [p_num_reqs-1:0] req_val,
  output logic [p_num_reqs-1:0] req_rdy,
  output mem_resp_4B_t          resp_msg [p_num_reqs],
  output logic [p_num_reqs-1:0] resp_val,
  input  logic [p_num_reqs-1:0] resp_rdy,
  output mem_req_4B_t           mem_reqstream_msg,
  output logic                  mem_reqstream_val,
  input  logic                  mem_reqstream_rdy,
  input  mem_resp_4B_t          mem_respstream_msg,
  input  logic                  mem_respstream_val,
  output logic                  mem_respstream_rdy,
  output logic                  err
);
  localparam int CW = $clog2(p_max_outstanding + 1);
  logic [CW-1:0] count;
  logic [p_num_reqs-1:0] grant;
  arb_id_t gidx;
  logic room, req_fire, resp_fire, bad, sel_rdy, rs_val, rs_rdy;
  mem_resp_4B_t rs_msg;
  assign room = count < CW'(p_max_outstanding);
  assign mem_reqstream_val = |req_val & room;
  assign req_rdy = grant & {p_num_reqs{mem_reqstream_rdy & room}};
  assign req_fire = mem_reqstream_val & mem_reqstream_rdy;
  lab2_proc_rr_arbiter #(.p_num_reqs(p_num_reqs)) u_arb (
    .clk(clk),
    .reset(reset),
    .req_val(req_val),
    .fire(req_fire),
    .hold(mem_reqstream_val & ~mem_reqstream_rdy),
    .grant(grant),
    .grant_idx(gidx)
  );
  // forward the granted message, retagged with its requester index
  always_comb begin
    mem_reqstream_msg = req_msg[0];
    for (int i = 0; i < p_num_reqs; i++) if (grant[i]) mem_reqstream_msg = req_msg[i];
    mem_reqstream_msg.opaque = arb_id_to_opaque(gidx);
  end
`ifdef LAB2_PROC_MEM_ARB_RESP_PIPE_EN
  mem_resp_4B_t q [2];
  logic [1:0] q_n;
  logic q_h, q_t, enq, deq;
  assign enq = mem_respstream_val & mem_respstream_rdy;
  assign deq = rs_val & rs_rdy;
  assign mem_respstream_rdy = q_n != 2'd2;
  assign rs_val = q_n != 2'd0;
  assign rs_msg = q[q_h];
  // two-entry circular buffer registering the shared response before steering
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_n <= 2'd0;
      q_h <= 1'b0;
      q_t <= 1'b0;
    end else begin
      if (enq) q[q_t] <= mem_respstream_msg;
      q_t <= q_t ^ enq;
      q_h <= q_h ^ deq;
      q_n <= q_n + {1'b0, enq} - {1'b0, deq};
    end
  end
`else
  assign rs_msg = mem_respstream_msg;
  assign rs_val = mem_respstream_val;
  assign mem_respstream_rdy = rs_rdy;
`endif
  assign bad = rs_msg.opaque >= 8'(p_num_reqs);
  assign rs_rdy = bad | sel_rdy;
  assign resp_fire = rs_val & rs_rdy;
  // steer the response by tag; unknown tags are swallowed
  always_comb begin
    sel_rdy = 1'b0;
    for (int i = 0; i < p_num_reqs; i++) begin
      resp_val[i] = rs_val && (rs_msg.opaque == 8'(i));
      sel_rdy = sel_rdy | (resp_rdy[i] && (rs_msg.opaque == 8'(i)));
      resp_msg[i] = rs_msg;
      resp_msg[i].opaque = 8'h00;
    end
  end
  // outstanding count saturating at zero, and sticky bad-tag flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
      err <= 1'b0;
    end else begin
      count <= (req_fire && !resp_fire) ? count + 1'b1 :
               (!req_fire && resp_fire && count != '0) ? count - 1'b1 : count;
      err <= err | (rs_val & bad);
    end
  end
endmodule

// File: tb/tb_lab2_proc_mem_port_arbiter.sv
// tb_lab2_proc_mem_port_arbiter: directed scoreboard bench for the memory port arbiter
module tb_lab2_proc_mem_port_arbiter;
  import lab2_proc_mem_arb_pkg::*;
  localparam int N = 2;
  localparam int MAXO = 2;
  logic clk = 1'b0;
  logic reset;
  mem_req_4B_t req_msg [N];
  logic [N-1:0] req_val, req_rdy, resp_val, resp_rdy;
  mem_resp_4B_t resp_msg [N];
  mem_req_4B_t mq_msg;
  logic mq_val, mq_rdy;
  mem_resp_4B_t ms_msg;
  logic ms_val, ms_rdy, err;
  int passes = 0;
  int total = 0;
  logic [7:0] exp_q [$];
  logic [7:0] out_q [$];
  int m_ptr;
  logic [7:0] e, r;

  lab2_proc_mem_port_arbiter #(.p_num_reqs(N), .p_max_outstanding(MAXO)) dut (
    .clk(clk),
    .reset(reset),
    .req_msg(req_msg),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .resp_msg(resp_msg),
    .resp_val(resp_val),
    .resp_rdy(resp_rdy),
    .mem_reqstream_msg(mq_msg),
    .mem_reqstream_val(mq_val),
    .mem_reqstream_rdy(mq_rdy),
    .mem_respstream_msg(ms_msg),
    .mem_respstream_val(ms_val),
    .mem_respstream_rdy(ms_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    req_val = '0;
    resp_rdy = '0;
    mq_rdy = 1'b1;
    ms_val = 1'b0;
    ms_msg = '0;
    for (int i = 0; i < N; i++) req_msg[i] = '0;
    m_ptr = 0;
    step();
    step();
    chk("rst_mq_val", mq_val, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;

    req_msg[0].addr = 32'h100;
    req_msg[0].data = 32'h11;
    req_msg[1].addr = 32'h200;
    req_val = 2'b01;
    exp_q.push_back(8'h00);
    #1;
    chk("single_val", mq_val, 1);
    chk("single_opaque", mq_msg.opaque, exp_q.pop_front());
    chk("single_addr", mq_msg.addr, 32'h100);
    chk("single_req_rdy", req_rdy, 2'b01);
    out_q.push_back(8'h00);
    m_ptr = 1;
    step();
    req_val = '0;
    chk("single_count", dut.count, 1);
    ms_val = 1'b1;
    ms_msg.opaque = out_q.pop_front();
    ms_msg.data = 32'hdeadbeef;
    resp_rdy = 2'b11;
    #1;
    chk("single_resp_val", resp_val, 2'b01);
    chk("single_resp_data", resp_msg[0].data, 32'hdeadbeef);
    chk("single_resp_opaque", resp_msg[0].opaque, 0);
    chk("single_ms_rdy", ms_rdy, 1);
    step();
    ms_val = 1'b0;
    chk("single_count_back", dut.count, 0);

    req_val = 2'b11;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(m_ptr));
      ms_val = out_q.size() != 0;
      if (ms_val) begin
        r = out_q.pop_front();
        ms_msg.opaque = r;
        ms_msg.data = 32'ha0 + i;
      end
      #1;
      e = exp_q.pop_front();
      chk("fair_opaque", mq_msg.opaque, e);
      chk("fair_addr", mq_msg.addr, e == 8'd0 ? 32'h100 : 32'h200);
      if (ms_val) chk("fair_resp_val", resp_val, 32'(1) << r);
      out_q.push_back(e);
      m_ptr = (int'(e) + 1) % N;
      step();
    end
    chk("fair_count", dut.count, 1);
    req_val = '0;
    ms_val = 1'b1;
    r = out_q.pop_front();
    ms_msg.opaque = r;
    #1;
    chk("fair_drain_val", resp_val, 32'(1) << r);
    step();
    ms_val = 1'b0;
    chk("fair_drain_count", dut.count, 0);

    mq_rdy = 1'b0;
    req_val = 2'b10;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) req_val = 2'b11;
      #1;
      chk("bp_opaque", mq_msg.opaque, 1);
      chk("bp_addr", mq_msg.addr, 32'h200);
      chk("bp_req_rdy", req_rdy, 0);
      step();
      chk("bp_locked", dut.u_arb.locked, 1);
    end
    mq_rdy = 1'b1;
    #1;
    chk("bp_fire_opaque", mq_msg.opaque, 1);
    chk("bp_fire_rdy", req_rdy, 2'b10);
    out_q.push_back(8'h01);
    m_ptr = 0;
    step();
    #1;
    chk("bp_next_opaque", mq_msg.opaque, 0);
    chk("bp_next_rdy", req_rdy, 2'b01);
    out_q.push_back(8'h00);
    m_ptr = 1;
    step();

    chk("lim_count", dut.count, MAXO);
    chk("lim_val", mq_val, 0);
    chk("lim_rdy", req_rdy, 0);
    ms_val = 1'b1;
    r = out_q.pop_front();
    ms_msg.opaque = r;
    #1;
    chk("lim_same_cycle", mq_val, 0);
    chk("lim_resp_val", resp_val, 32'(1) << r);
    step();
    ms_val = 1'b0;
    #1;
    chk("lim_next_val", mq_val, 1);
    chk("lim_next_opaque", mq_msg.opaque, m_ptr);
    out_q.push_back(8'(m_ptr));
    step();
    req_val = '0;
    for (int i = 0; i < 2; i++) begin
      ms_val = 1'b1;
      r = out_q.pop_front();
      ms_msg.opaque = r;
      #1;
      chk("drain_resp_val", resp_val, 32'(1) << r);
      step();
    end
    ms_val = 1'b0;
    chk("drain_count", dut.count, 0);

    ms_val = 1'b1;
    ms_msg.opaque = 8'h05;
    resp_rdy = '0;
    #1;
    chk("bad_ms_rdy", ms_rdy, 1);
    chk("bad_resp_val", resp_val, 0);
    step();
    ms_val = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_count_sat", dut.count, 0);
    step();
    chk("bad_err_sticky", err, 1);
    resp_rdy = 2'b11;

    req_val = 2'b01;
    step();
    mq_rdy = 1'b0;
    step();
    chk("rl_locked", dut.u_arb.locked, 1);
    chk("rl_ptr_pre", dut.u_arb.ptr, 1);
    chk("rl_count_pre", dut.count, 1);
    reset = 1'b0;
    step();
    chk("rl_locked_clr", dut.u_arb.locked, 0);
    chk("rl_ptr_clr", dut.u_arb.ptr, 0);
    chk("rl_count_clr", dut.count, 0);
    chk("rl_err_clr", err, 0);
    reset = 1'b1;
    req_val = '0;
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/lab2_proc_mem_port_arbiter.md
# lab2_proc_mem_port_arbiter

Round-robin arbiter that shares one 4B memory request/response port among `p_num_reqs` requesters, for example the imem and dmem streams of one core, or the dmem streams of several cores. Requests are tagged with the requester index in the `opaque` field. Responses are steered back by that tag. The block sits between the processors' bypass request queues and the shared memory/cache port.

## Interface
- `p_num_reqs`, default 2: number of requesters, 2..8.
- `p_max_outstanding`, default 4: maximum requests in flight awaiting a response, 1..15.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset (asserted when 0).
- `req_msg[p_num_reqs]` in `mem_req_4B_t`: requester request messages.
- `req_val[p_num_reqs]` in 1: request valid.
- `req_rdy[p_num_reqs]` out 1: request accepted.
- `resp_msg[p_num_reqs]` out `mem_resp_4B_t`: response to each requester, with `opaque` forced to 0.
- `resp_val[p_num_reqs]` out 1: response valid.
- `resp_rdy[p_num_reqs]` in 1: requester can take the response.
- `mem_reqstream_msg` out `mem_req_4B_t`: merged request.
- `mem_reqstream_val` out 1 and `mem_reqstream_rdy` in 1: merged request handshake.
- `mem_respstream_msg` in `mem_resp_4B_t`: shared response.
- `mem_respstream_val` in 1 and `mem_respstream_rdy` out 1: shared response handshake.
- `err` out 1: sticky flag, set on a response whose `opaque` does not name a valid requester.

## Operation
- **State**
  - `ptr`: priority pointer, `clog2(p_num_reqs)` bits.
  - `locked` and `lock_id`: grant hold.
  - `count`: outstanding requests, `clog2(p_max_outstanding+1)` bits.
  - `err`.
- **Grant selection**
  - If `locked`, grant = `lock_id`.
  - Otherwise grant = the first requester with `req_val` set, scanning `ptr`, `ptr+1`, … modulo `p_num_reqs`.
- **Request path**
  - `mem_reqstream_val` = (any `req_val`) and (`count < p_max_outstanding`).
  - `mem_reqstream_msg` = the granted `req_msg`, with `opaque` = grant index zero-extended to 8 bits; all other fields pass through.
  - `req_rdy[i]` = (`i` == grant) and `mem_reqstream_rdy` and (`count < p_max_outstanding`).
- **Request fire** (val & rdy):
  - `ptr` ← (grant+1) mod `p_num_reqs`;
  - `locked` ← 0;
  - `count` increments.
- **Val without rdy**
  - `locked` ← 1 and `lock_id` ← grant.
  - The output message stays stable until it fires; any newly valid requester is ignored meanwhile.
- **Response path**
  - With `id` = `mem_respstream_msg.opaque`: `resp_val[id]` = `mem_respstream_val`, and `mem_respstream_rdy` = `resp_rdy[id]`.
  - Every `resp_msg[i]` = the shared response with `opaque` = 0.
  - When `id` ≥ `p_num_reqs`: `mem_respstream_rdy` = 1, the response is dropped, and `err` ← 1.
  - A response fire (including a dropped one) decrements `count`.
- **Counter rules**
  - A request fire and a response fire in the same cycle leave `count` unchanged.
  - `count` saturates at 0; a response arriving after reset never underflows it.

## Timing
- Reset values: `ptr`=0, `locked`=0, `count`=0, `err`=0.
  - Consequently `mem_reqstream_val`=0 and all `req_rdy`=0 while all `req_val` are low.
- Request path is combinational: 0-cycle latency from `req_val` to `mem_reqstream_val`.
- Response path is 0-cycle latency when the response pipe is not compiled in (see Configuration).
- A reset asserted while locked takes effect at the next edge; the pending grant is abandoned.
- At `count == p_max_outstanding`, a response fire in cycle t permits a request fire in cycle t+1. It does not permit one in cycle t, because the `count` check uses the registered value.

## Configuration
- `LAB2_PROC_MEM_ARB_RESP_PIPE_EN` defined:
  - A 2-entry normal `vc_Queue` registers the shared response before steering.
  - `mem_respstream_rdy` = the queue's `enq_rdy`; bad-opaque responses are dropped at dequeue.
  - Response latency is 1 cycle.
  - `count` decrements on dequeue to the requester, not on enqueue.
- Not defined: the response path is purely combinational, as described in Operation.

## Structure
- Shared package `lab2_proc_mem_arb_pkg` holds:
  - constant `ARB_MAX_REQS` = 8;
  - typedef `arb_id_t` (3 bits);
  - a function mapping `arb_id_t` to an 8-bit `opaque`.
- One sub-module, `lab2_proc_rr_arbiter`, holds `ptr`, `locked` and `lock_id`, and produces a one-hot grant plus its index.

## Test plan
- **Idle single request:** `req_val[0]`=1, addr 0x100, `mem_reqstream_rdy`=1 → same cycle `mem_reqstream_val`=1, `opaque`=0x00, `count`=1. Response `opaque`=0, data 0xdeadbeef → `resp_val[0]`=1 with that data in the same cycle (1 cycle later with the macro defined).
- **Fairness:** `req_val[0]` and `req_val[1]` held at 1 with `mem_reqstream_rdy`=1 and responses returned each cycle → grants 0,1,0,1; request opaques 0x00, 0x01 alternate.
- **Backpressure lock:** requester 1 granted, `mem_reqstream_rdy`=0 for 3 cycles while `req_val[0]` rises → message stays requester 1's, unchanged; after it fires, requester 0 is granted next.
- **Outstanding limit** (`p_max_outstanding`=2): two fires with no responses → `mem_reqstream_val`=0. A response in cycle t → a request fires in cycle t+1.
- **Bad tag** (`p_num_reqs`=2): response `opaque`=0x05 → `mem_respstream_rdy`=1, no `resp_val`, `err`=1 held until reset.
- **Reset mid-lock:** `reset`=0 during a lock → next cycle `locked`=0, `ptr`=0, `count`=0, `err`=0.
